// File: rtl/iterative_alu.sv
`default_nettype none
// ============================================================================
//  Module      : iterative_alu
//  Description : Execution unit with valid/ready handshakes on both sides.
//                Arithmetic, logic and branch-compare ops complete in one
//                cycle; shifts move one bit per cycle (latency 1+shamt).
//                Define ALU_BARREL_SHIFT_EN for a single-cycle barrel
//                shifter (all ops latency 1, no SHIFT state or counter).
//  Revision    : 1.0 - initial release
// ============================================================================
module iterative_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_in_1,
  input  logic [DATA_WIDTH-1:0] alu_in_2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  alu_bcond
);

  localparam logic [3:0] C_OP_ADD = 4'd0;
  localparam logic [3:0] C_OP_SUB = 4'd1;
  localparam logic [3:0] C_OP_AND = 4'd2;
  localparam logic [3:0] C_OP_OR  = 4'd3;
  localparam logic [3:0] C_OP_XOR = 4'd4;
  localparam logic [3:0] C_OP_SLL = 4'd5;
  localparam logic [3:0] C_OP_SRL = 4'd6;
  localparam logic [3:0] C_OP_SRA = 4'd7;
  localparam logic [3:0] C_OP_BEQ = 4'd8;
  localparam logic [3:0] C_OP_BNE = 4'd9;
  localparam logic [3:0] C_OP_BLT = 4'd10;
  localparam logic [3:0] C_OP_BGE = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_result;
  logic                    r_bcond;

  logic [DATA_WIDTH-1:0]   w_result;
  logic                    w_bcond;
  logic [DATA_WIDTH-1:0]   w_diff;
  logic [SHAMT_WIDTH-1:0]  w_shamt;

  assign w_shamt = alu_in_2[SHAMT_WIDTH-1:0];
  assign w_diff  = alu_in_1 - alu_in_2;

  // Accept only in IDLE; forced low while reset is asserted
  assign in_ready   = (r_state == S_IDLE) && !reset;
  assign out_valid  = r_out_valid;
  assign alu_result = r_result;
  assign alu_bcond  = r_bcond;

  // Single-cycle result of the op currently presented on the input side
  always_comb begin
    w_result = alu_in_1 + alu_in_2;
    w_bcond  = 1'b0;
    case (alu_op)
      C_OP_SUB: w_result = w_diff;
      C_OP_AND: w_result = alu_in_1 & alu_in_2;
      C_OP_OR:  w_result = alu_in_1 | alu_in_2;
      C_OP_XOR: w_result = alu_in_1 ^ alu_in_2;
`ifdef ALU_BARREL_SHIFT_EN
      C_OP_SLL: w_result = alu_in_1 << w_shamt;
      C_OP_SRL: w_result = alu_in_1 >> w_shamt;
      C_OP_SRA: w_result = $signed(alu_in_1) >>> w_shamt;
`else
      // Only reached with a zero shift amount: result is operand A
      C_OP_SLL, C_OP_SRL, C_OP_SRA: w_result = alu_in_1;
`endif
      C_OP_BEQ: begin w_result = w_diff; w_bcond = (alu_in_1 == alu_in_2); end
      C_OP_BNE: begin w_result = w_diff; w_bcond = (alu_in_1 != alu_in_2); end
      C_OP_BLT: begin w_result = w_diff; w_bcond = ($signed(alu_in_1) <  $signed(alu_in_2)); end
      C_OP_BGE: begin w_result = w_diff; w_bcond = ($signed(alu_in_1) >= $signed(alu_in_2)); end
      default:  ;  // codes 12-15 execute as ADD
    endcase
  end

`ifndef ALU_BARREL_SHIFT_EN
  logic [3:0]              r_op;
  logic [SHAMT_WIDTH-1:0]  r_cnt;
  logic                    w_is_shift;
  logic [DATA_WIDTH-1:0]   w_step;

  assign w_is_shift = (alu_op == C_OP_SLL) || (alu_op == C_OP_SRL) || (alu_op == C_OP_SRA);

  // One-bit shift of the working register (r_result doubles as it)
  always_comb begin
    w_step = r_result;
    case (r_op)
      C_OP_SLL: w_step = {r_result[DATA_WIDTH-2:0], 1'b0};
      C_OP_SRL: w_step = {1'b0, r_result[DATA_WIDTH-1:1]};
      C_OP_SRA: w_step = {r_result[DATA_WIDTH-1], r_result[DATA_WIDTH-1:1]};
      default:  ;
    endcase
  end
`endif

  // Control FSM with registered result, branch flag and output valid
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_bcond     <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      r_cnt       <= '0;
      r_op        <= C_OP_ADD;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // in_ready is high whenever we are here with reset low
          if (in_valid) begin
`ifndef ALU_BARREL_SHIFT_EN
            r_op  <= alu_op;
            r_cnt <= w_shamt;
            if (w_is_shift && (w_shamt != '0)) begin
              r_result <= alu_in_1;
              r_bcond  <= 1'b0;
              r_state  <= S_SHIFT;
            end else
`endif
            begin
              r_result    <= w_result;
              r_bcond     <= w_bcond;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
`ifndef ALU_BARREL_SHIFT_EN
        S_SHIFT: begin
          r_result <= w_step;
          r_cnt    <= r_cnt - SHAMT_WIDTH'(1);
          if (r_cnt == SHAMT_WIDTH'(1)) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iterative_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iterative_alu
//  Description : Self-checking bench for iterative_alu: a table of directed
//                vectors plus hand-written stall and reset-abort sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iterative_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_in_1;
  logic [31:0] alu_in_2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic        alu_bcond;

  int n_cmp  = 0;
  int n_fail = 0;

  iterative_alu #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .alu_in_1   (alu_in_1),
    .alu_in_2   (alu_in_2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .alu_bcond  (alu_bcond)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        bc;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    if (op >= 4'd5 && op <= 4'd7) return 1 + int'(b[4:0]);
    return 1;
`endif
  endfunction

  // Present one op before the next edge, then scramble the inputs and count
  // cycles until out_valid (bounded).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    @(negedge clk);
    check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; alu_op = op; alu_in_1 = a; alu_in_2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_op   = 4'($urandom_range(0, 15));
    alu_in_1 = $urandom;
    alu_in_2 = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_take", {31'd0, out_valid}, 32'd0);
    check("in_ready_after_take",  {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
    vecs[1]  = '{4'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{4'd2,  32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 1'b0};
    vecs[3]  = '{4'd3,  32'h12000000, 32'h00340056, 32'h12340056, 1'b0};
    vecs[4]  = '{4'd4,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0};
    vecs[5]  = '{4'd7,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0};
    vecs[6]  = '{4'd5,  32'h00000001, 32'h00000000, 32'h00000001, 1'b0};
    vecs[7]  = '{4'd5,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0};
    vecs[8]  = '{4'd6,  32'h80000000, 32'h00000024, 32'h08000000, 1'b0};
    vecs[9]  = '{4'd7,  32'h7FFF0000, 32'h00000008, 32'h007FFF00, 1'b0};
    vecs[10] = '{4'd5,  32'h00000003, 32'h00000005, 32'h00000060, 1'b0};
    vecs[11] = '{4'd8,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1};
    vecs[12] = '{4'd8,  32'h00000005, 32'h00000006, 32'hFFFFFFFF, 1'b0};
    vecs[13] = '{4'd9,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
    vecs[14] = '{4'd10, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1};
    vecs[15] = '{4'd11, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[16] = '{4'd11, 32'h00000003, 32'h00000003, 32'h00000000, 1'b1};
    vecs[17] = '{4'd10, 32'h00000001, 32'hFFFFFFFF, 32'h00000002, 1'b0};
    vecs[18] = '{4'd12, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0};
    vecs[19] = '{4'd15, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 4'd0; alu_in_1 = '0; alu_in_2 = '0;

    // Reset state
    @(posedge clk); #1;
    check("in_ready_during_reset", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("out_valid_reset",  {31'd0, out_valid}, 32'd0);
    check("result_reset",     alu_result,         32'd0);
    check("bcond_reset",      {31'd0, alu_bcond}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Directed vectors
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("latency[%0d]", i), 32'(lat), 32'(exp_lat(vecs[i].op, vecs[i].b)));
      check($sformatf("result[%0d]", i),  alu_result, vecs[i].res);
      check($sformatf("bcond[%0d]", i),   {31'd0, alu_bcond}, {31'd0, vecs[i].bc});
      handshake();
    end

    // Stall in DONE: output held, in_valid pulses ignored
    issue(4'd4, 32'hAAAA5555, 32'h0000FFFF, lat);
    check("stall_latency", 32'(lat), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; alu_op = 4'd0; alu_in_1 = 32'(k); alu_in_2 = 32'd100;
      @(posedge clk); #1;
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_result",    alu_result,         32'hAAAAAAAA);
      check("stall_in_ready",  {31'd0, in_ready},  32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("bubble_out_valid", {31'd0, out_valid}, 32'd0);
    check("bubble_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;
    check("bubble_no_accept", {31'd0, out_valid}, 32'd0);

    // Reset during SRL by 20 (accepted at T, reset sampled at T+3)
    issue_no_wait(4'd6, 32'hFFFFFFFF, 32'd20);
    @(posedge clk); #1;  // T+1
    check("abort_in_ready_busy", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b1; alu_op = 4'd0; alu_in_1 = 32'd1; alu_in_2 = 32'd1;
    @(posedge clk); #1;  // T+2
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;  // T+3
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_result",    alu_result,         32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_in_ready_idle", {31'd0, in_ready}, 32'd1);
    begin
      int seen = 0;
      for (int k = 0; k < 25; k++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check("abort_no_out_valid", 32'(seen), 32'd0);
    end
    issue(4'd1, 32'd10, 32'd3, lat);
    check("post_abort_latency", 32'(lat), 32'd1);
    check("post_abort_result",  alu_result, 32'd7);
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Present one op and return right after the accepting edge
  task automatic issue_no_wait(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; alu_op = op; alu_in_1 = a; alu_in_2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

endmodule
`default_nettype wire
